// File: rtl/vga_sync_receiver.sv
// VGA timing receiver: registers the syncs, recovers the pixel position, qualifies
// line and frame timing over whole frames and passes pixels only from a locked stream.
module vga_sync_receiver #(
   parameter int H_SYNC      = 96,
   parameter int H_BACK      = 48,
   parameter int H_DISP      = 640,
   parameter int H_FRONT     = 16,
   parameter int H_TOTAL     = 800,
   parameter int V_SYNC      = 2,
   parameter int V_BACK      = 33,
   parameter int V_DISP      = 480,
   parameter int V_FRONT     = 10,
   parameter int V_TOTAL     = 525,
   parameter int LOCK_FRAMES = 2
) (
   input  logic        driver_clk,
   input  logic        sys_rst,
   input  logic        Hsync,
   input  logic        Fsync,
   input  logic [29:0] data_in,
   output logic [29:0] data_out,
   output logic        data_valid,
   output logic [9:0]  pixel_xpos,
   output logic [9:0]  pixel_ypos,
   output logic        frame_start,
   output logic        locked,
   output logic        timing_err
);

   localparam logic [9:0] POS_MAX  = 10'h3FF;
   localparam logic [9:0] H_SYNC_W = 10'(H_SYNC);
   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT_LO = 10'(H_SYNC + H_BACK);
   localparam logic [9:0] H_ACT_HI = 10'(H_TOTAL - H_FRONT - 1);
   localparam logic [9:0] V_ACT_LO = 10'(V_SYNC + V_BACK);
   localparam logic [9:0] V_ACT_HI = 10'(V_TOTAL - V_FRONT - 1);
   localparam logic [9:0] H_DISP_W = 10'(H_DISP);
   localparam logic [9:0] V_DISP_W = 10'(V_DISP);
   localparam logic [7:0] LOCK_CNT = 8'(LOCK_FRAMES);

   typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

   state_t      state, state_n;
   logic        hs_q, hs_qq, vs_q, vs_line;
   logic [29:0] data_q;
   logic [9:0]  hpos_r, vpos_r;
   logic        sync_ok, frame_bad;
   logic [7:0]  good_cnt, good_cnt_n;

   logic        line_start, hs_rise, frame_start_ev, line_bad, frame_good, active;
   logic [9:0]  hpos, vpos, xoff, yoff;
   logic        vs_line_n, sync_ok_n, frame_bad_n;

   // hpos/vpos locate the pixel now in data_q; hpos_r/vpos_r hold the previous cycle's values.
   // NOTE: every always_comb output is given a default first so no path can infer a latch.
   always_comb begin
      line_start     = hs_qq & ~hs_q;
      hs_rise        = ~hs_qq & hs_q;
      frame_start_ev = line_start & ~vs_q & vs_line;
      hpos           = line_start ? 10'd0 : ((hpos_r == POS_MAX) ? POS_MAX : hpos_r + 10'd1);
      line_bad       = ~sync_ok | (hpos_r != H_LAST);
      frame_good     = ~(frame_bad | line_bad) & (vpos_r == V_LAST);
      vpos           = vpos_r;
      vs_line_n      = vs_line;
      sync_ok_n      = sync_ok;
      frame_bad_n    = frame_bad;
      if (hs_rise)
         sync_ok_n = (hpos == H_SYNC_W);
      if (line_start) begin
         vs_line_n = vs_q;
         sync_ok_n = 1'b0;
         if (frame_start_ev) begin
            vpos        = 10'd0;
            frame_bad_n = 1'b0;
         end else begin
            vpos        = (vpos_r == POS_MAX) ? POS_MAX : vpos_r + 10'd1;
            frame_bad_n = frame_bad | line_bad;
         end
      end
      xoff   = hpos - H_ACT_LO;
      yoff   = vpos - V_ACT_LO;
      active = (hpos >= H_ACT_LO) && (hpos <= H_ACT_HI) && (xoff < H_DISP_W) &&
               (vpos >= V_ACT_LO) && (vpos <= V_ACT_HI) && (yoff < V_DISP_W);
   end

   // The line that ends on a frame start is folded into frame_good before judging the frame.
   always_comb begin
      state_n    = state;
      good_cnt_n = good_cnt;
      case (state)
         SEARCH: begin
            if (frame_start_ev) begin
               state_n    = CHECK;
               good_cnt_n = 8'd0;
            end
         end
         CHECK: begin
            if (frame_start_ev) begin
               good_cnt_n = frame_good ? good_cnt + 8'd1 : 8'd0;
               if (good_cnt_n == LOCK_CNT)
                  state_n = LOCKED;
            end
         end
         LOCKED: begin
            if ((line_start && line_bad) || (frame_start_ev && (vpos_r != V_LAST)))
               state_n = SEARCH;
         end
         default: state_n = SEARCH;
      endcase
      if (hpos == POS_MAX)
         state_n = SEARCH;
   end

   always_ff @(posedge driver_clk) begin
      if (sys_rst)
         state <= SEARCH;
      else
         state <= state_n;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge driver_clk) begin
      if (sys_rst) begin
         hs_q        <= 1'b1;
         hs_qq       <= 1'b1;
         vs_q        <= 1'b1;
         vs_line     <= 1'b1;
         data_q      <= '0;
         hpos_r      <= '0;
         vpos_r      <= '0;
         sync_ok     <= 1'b0;
         frame_bad   <= 1'b0;
         good_cnt    <= '0;
         data_out    <= '0;
         data_valid  <= 1'b0;
         pixel_xpos  <= '0;
         pixel_ypos  <= '0;
         frame_start <= 1'b0;
         locked      <= 1'b0;
         timing_err  <= 1'b0;
      end else begin
         hs_q        <= Hsync;
         hs_qq       <= hs_q;
         vs_q        <= Fsync;
         data_q      <= data_in;
         hpos_r      <= hpos;
         vpos_r      <= vpos;
         vs_line     <= vs_line_n;
         sync_ok     <= sync_ok_n;
         frame_bad   <= frame_bad_n;
         good_cnt    <= good_cnt_n;
         data_valid  <= active && (state_n == LOCKED);
         data_out    <= (active && (state_n == LOCKED)) ? data_q : '0;
         pixel_xpos  <= active ? xoff : '0;
         pixel_ypos  <= active ? yoff : '0;
         frame_start <= frame_start_ev && (state_n == LOCKED);
         locked      <= (state_n == LOCKED);
         timing_err  <= (state == LOCKED) && (state_n != LOCKED);
      end
   end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Scoreboard bench for vga_sync_receiver on a shrunken raster (17x9) so whole
// lock/unlock scenarios fit in a few thousand cycles.
module tb_vga_sync_receiver;

   localparam int H_SYNC = 4, H_BACK = 3, H_DISP = 8, H_FRONT = 2, H_TOTAL = 17;
   localparam int V_SYNC = 2, V_BACK = 2, V_DISP = 4, V_FRONT = 1, V_TOTAL = 9;
   localparam int HA = H_SYNC + H_BACK;
   localparam int VA = V_SYNC + V_BACK;
   localparam int LOSS = 1023 - H_TOTAL;

   typedef struct packed {
      logic        all_zero;
      logic        valid;
      logic [29:0] data;
      logic [9:0]  x;
      logic [9:0]  y;
      logic        fs;
      logic        lock;
      logic        err;
   } exp_t;

   logic        driver_clk, sys_rst, Hsync, Fsync;
   logic [29:0] data_in, data_out;
   logic        data_valid, frame_start, locked, timing_err;
   logic [9:0]  pixel_xpos, pixel_ypos;

   exp_t        exp_q[$];
   exp_t        mon_e;
   logic [53:0] mon_got, mon_want;
   int          n_vec, n_fail, n_dv, n_err, n_lock;
   int          snap_err, snap_lock;
   string       phase;

   vga_sync_receiver #(
      .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_DISP(H_DISP), .H_FRONT(H_FRONT), .H_TOTAL(H_TOTAL),
      .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_DISP(V_DISP), .V_FRONT(V_FRONT), .V_TOTAL(V_TOTAL),
      .LOCK_FRAMES(2)
   ) dut (
      .driver_clk(driver_clk), .sys_rst(sys_rst), .Hsync(Hsync), .Fsync(Fsync),
      .data_in(data_in), .data_out(data_out), .data_valid(data_valid),
      .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos), .frame_start(frame_start),
      .locked(locked), .timing_err(timing_err)
   );

   initial driver_clk = 1'b0;
   always #5 driver_clk = ~driver_clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_vec++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s t=%0t got=%h want=%h", tag, $time, got, want);
      end
   endtask

   function automatic exp_t rst_exp();
      rst_exp          = '0;
      rst_exp.all_zero = 1'b1;
   endfunction

   // A reset edge also wipes the output that the previously driven cycle would have produced.
   task automatic step(input logic hs, input logic vs, input logic [29:0] d, input logic rst,
                       input exp_t e);
      @(negedge driver_clk);
      Hsync   = hs;
      Fsync   = vs;
      data_in = d;
      sys_rst = rst;
      if (rst && exp_q.size() > 0)
         exp_q[exp_q.size() - 1] = rst_exp();
      exp_q.push_back(rst ? rst_exp() : e);
   endtask

   task automatic drive_reset(input int n);
      for (int i = 0; i < n; i++)
         step(i[0], !i[0], 30'($urandom), 1'b1, rst_exp());
   endtask

   task automatic drive_line(input int len, input int v, input bit lock, input bit err,
                             input int rst_h);
      exp_t        e;
      logic [29:0] d;
      bit          act, lk;
      for (int h = 0; h < len; h++) begin
         act     = (h >= HA) && (h < HA + H_DISP) && (v >= VA) && (v < VA + V_DISP);
         lk      = lock && !(rst_h >= 0 && h >= rst_h);
         d       = act ? {10'd0, 10'(v - VA), 10'(h - HA)} : 30'($urandom);
         e       = '0;
         e.lock  = lk;
         e.valid = lk && act;
         e.data  = e.valid ? d : 30'd0;
         e.x     = e.valid ? 10'(h - HA) : 10'd0;
         e.y     = e.valid ? 10'(v - VA) : 10'd0;
         e.fs    = lk && (h == 0) && (v == 0);
         e.err   = err && (h == 0);
         step(h >= H_SYNC, v >= V_SYNC, d, h == rst_h, e);
      end
   endtask

   task automatic drive_frame(input int n_lines, input bit lock);
      for (int v = 0; v < n_lines; v++)
         drive_line(H_TOTAL, v, lock, 1'b0, -1);
   endtask

   task automatic drive_stuck(input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e      = '0;
         e.lock = (i < LOSS);
         e.err  = (i == LOSS);
         step(1'b1, 1'b1, 30'($urandom), 1'b0, e);
      end
   endtask

   // Output of the cycle driven two edges ago; positions are only defined for valid or reset cycles.
   initial begin
      forever begin
         @(posedge driver_clk);
         #1;
         if (exp_q.size() >= 2) begin
            mon_e    = exp_q.pop_front();
            mon_got  = {data_valid, data_out,
                        (mon_e.valid | mon_e.all_zero) ? pixel_xpos : 10'd0,
                        (mon_e.valid | mon_e.all_zero) ? pixel_ypos : 10'd0,
                        frame_start, locked, timing_err};
            mon_want = {mon_e.valid, mon_e.data, mon_e.x, mon_e.y, mon_e.fs, mon_e.lock, mon_e.err};
            check(phase, 64'(mon_got), 64'(mon_want));
         end
         if (data_valid) n_dv++;
         if (timing_err) n_err++;
         if (locked) n_lock++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: stimulus did not complete in time");
      $fatal(1);
   end

   initial begin
      n_vec = 0; n_fail = 0; n_dv = 0; n_err = 0; n_lock = 0;
      Hsync = 1'b1; Fsync = 1'b1; data_in = '0; sys_rst = 1'b1;

      phase = "reset";
      drive_reset(3);

      phase = "acquire";
      snap_err = n_err;
      drive_frame(V_TOTAL, 1'b0);
      drive_frame(V_TOTAL, 1'b0);
      n_dv = 0;
      drive_frame(V_TOTAL, 1'b1);
      check("valid_per_frame", 64'(n_dv), 64'(H_DISP * V_DISP));
      check("acquire_no_err", 64'(n_err - snap_err), 64'd0);

      phase = "short_line";
      snap_err = n_err;
      for (int v = 0; v < 5; v++) drive_line(H_TOTAL, v, 1'b1, 1'b0, -1);
      drive_line(H_TOTAL - 1, 5, 1'b1, 1'b0, -1);
      drive_line(H_TOTAL, 6, 1'b0, 1'b1, -1);
      for (int v = 7; v < V_TOTAL; v++) drive_line(H_TOTAL, v, 1'b0, 1'b0, -1);
      drive_frame(V_TOTAL, 1'b0);
      drive_frame(V_TOTAL, 1'b0);
      n_dv = 0;
      drive_frame(V_TOTAL, 1'b1);
      check("short_line_err_pulses", 64'(n_err - snap_err), 64'd1);
      check("relock_valid_per_frame", 64'(n_dv), 64'(H_DISP * V_DISP));

      phase = "hsync_stuck";
      snap_err = n_err;
      for (int v = 0; v < 6; v++) drive_line(H_TOTAL, v, 1'b1, 1'b0, -1);
      drive_stuck(1100);
      drive_frame(V_TOTAL, 1'b0);
      drive_frame(V_TOTAL, 1'b0);
      drive_frame(V_TOTAL, 1'b1);
      check("stuck_err_pulses", 64'(n_err - snap_err), 64'd1);

      phase = "short_frame_locked";
      snap_err = n_err;
      drive_frame(V_TOTAL - 1, 1'b1);
      drive_line(H_TOTAL, 0, 1'b0, 1'b1, -1);
      for (int v = 1; v < V_TOTAL; v++) drive_line(H_TOTAL, v, 1'b0, 1'b0, -1);
      drive_frame(V_TOTAL, 1'b0);
      drive_frame(V_TOTAL, 1'b0);
      drive_frame(V_TOTAL, 1'b1);
      check("line_count_err_pulses", 64'(n_err - snap_err), 64'd1);

      phase = "mid_reset";
      snap_err = n_err;
      for (int v = 0; v < 3; v++) drive_line(H_TOTAL, v, 1'b1, 1'b0, -1);
      drive_line(H_TOTAL, 3, 1'b1, 1'b0, 7);
      for (int v = 4; v < V_TOTAL; v++) drive_line(H_TOTAL, v, 1'b0, 1'b0, -1);
      drive_frame(V_TOTAL, 1'b0);
      drive_frame(V_TOTAL, 1'b0);
      drive_frame(V_TOTAL, 1'b1);
      check("mid_reset_no_err", 64'(n_err - snap_err), 64'd0);

      phase = "short_frames";
      drive_reset(3);
      snap_err  = n_err;
      snap_lock = n_lock;
      for (int f = 0; f < 5; f++) drive_frame(V_TOTAL - 1, 1'b0);
      check("short_frames_never_lock", 64'(n_lock - snap_lock), 64'd0);
      check("short_frames_no_err", 64'(n_err - snap_err), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_sync_receiver.md
VGA_SYNC_RECEIVER -- requirements
Module: vga_sync_receiver

Interface
REQ-001 SHALL have parameters: H_SYNC 96, hsync low width; H_BACK 48, back porch; H_DISP 640, active pixels; H_FRONT 16, front porch; H_TOTAL 800, line period; V_SYNC 2, V_BACK 33, V_DISP 480, V_FRONT 10, V_TOTAL 525, vertical equivalents in lines; LOCK_FRAMES 2, consecutive good frames needed to lock.
REQ-002 SHALL have ports: driver_clk  in  1  pixel clock, 25.175 MHz.
REQ-003 sys_rst  in  1  reset, synchronous, active-high.
REQ-004 Hsync  in  1  line sync, active-low.
REQ-005 Fsync  in  1  frame sync, active-low.
REQ-006 data_in  in  30  pixel data, sampled with syncs.
REQ-007 data_out  out  30  captured pixel, 0 when not valid.
REQ-008 data_valid  out  1  data_out is an active, locked pixel.
REQ-009 pixel_xpos / pixel_ypos  out  10 each  0-based active coordinates.
REQ-010 frame_start  out  1  one-cycle pulse with pixel (0,0) region start.
REQ-011 locked  out  1  timing lock status.
REQ-012 timing_err  out  1  one-cycle pulse on loss of lock.

Function
REQ-013 Hsync, Fsync, data_in SHALL be registered once (hs_q, vs_q, data_q); line start = cycle where previous hs_q=1 and hs_q=0.
REQ-014 hpos SHALL be 0 in the line-start cycle, else previous hpos+1, saturating at 1023.
REQ-015 At each line start vs_q SHALL be stored as vs_line; vpos SHALL become 0 when vs_q=0 and previous vs_line=1 (frame start), else vpos+1 saturating at 1023; vpos changes only at line starts.
REQ-016 Hsync low width SHALL be counted from line start to hs_q rising; a line is good iff low width = H_SYNC and the line-start-to-line-start period = H_TOTAL.
REQ-017 A frame is good iff all its lines are good and its line count = V_TOTAL; a per-frame sticky bad flag SHALL be cleared at each frame start.
REQ-018 Lock FSM states SEARCH, CHECK, LOCKED.
REQ-019 SEARCH -> CHECK at first frame start, good count = 0.
REQ-020 CHECK: at frame start, good frame increments good count, bad frame clears it; count reaching LOCK_FRAMES -> LOCKED in that cycle's update.
REQ-021 LOCKED -> SEARCH at the line start ending a bad line, at a frame start with wrong line count, or when hpos reaches 1023; timing_err SHALL pulse 1 cycle on that transition.
REQ-022 Any state -> SEARCH when hpos reaches 1023 (no Hsync); timing_err only when leaving LOCKED.
REQ-023 locked SHALL be 1 iff state is LOCKED (registered).
REQ-024 Active region: hpos in [H_SYNC+H_BACK, H_TOTAL-H_FRONT-1] = [144,783] and vpos in [V_SYNC+V_BACK, V_TOTAL-V_FRONT-1] = [35,514].
REQ-025 All outputs SHALL be registered; data_valid = active and locked; data_out = data_q if valid else 0; pixel_xpos = hpos-144, pixel_ypos = vpos-35 when active, else 0.
REQ-026 Latency data_in -> data_out SHALL be 2 cycles.
REQ-027 frame_start SHALL pulse 1 cycle, the cycle after a frame-start line start, only if state after that update is LOCKED.
REQ-028 Simultaneous frame start and bad-line detection SHALL count the line into the ending frame before evaluating it.

Reset
REQ-029 While sys_rst=1 at a clock edge: hs_q, vs_q, vs_line = 1; data_q, hpos, vpos, counters, flags = 0; state SEARCH; all outputs 0.
REQ-030 Reset mid-frame SHALL discard lock; relock requires full SEARCH/CHECK sequence.

Verification
REQ-031 sys_rst high 3 cycles, syncs toggling -> all outputs 0, locked 0 through reset and until lock.
REQ-032 Standard 640x480 stream, data_in = {10'h0,ypos,xpos} of source -> locked=1 after 3rd frame start; 307200 data_valid cycles per frame; first valid xpos=0, ypos=0, data_out 2 cycles after data_in.
REQ-033 While locked, one line shortened to 799 cycles -> timing_err one pulse, locked 0, data_valid 0; relocks after 3 further frame starts.
REQ-034 While locked, Hsync held high 1100 cycles -> locked drops when hpos reaches 1023, timing_err pulses once.
REQ-035 Stream with 524 lines/frame -> locked never asserts, timing_err never pulses.
REQ-036 sys_rst pulsed 1 cycle mid-frame while locked -> next cycle all outputs 0; locked returns only after 3 frame starts.
